// File: rtl/mem_datos_sinc_if.sv
// Request/response bundle between the MEM stage and the data memory.
// Plain handshake: Req qualified by Ready, read data flagged by Valid.
interface mem_datos_sinc_if;
    logic        Req;
    logic        Ewr;
    logic [1:0]  Tam;
    logic        Sig;
    logic [31:0] Dir;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        Valid;
    logic        Ready;
    logic        Err;

    modport master (
        output Req, Ewr, Tam, Sig, Dir, Din,
        input  Dout, Valid, Ready, Err
    );

    modport slave (
        input  Req, Ewr, Tam, Sig, Dir, Din,
        output Dout, Valid, Ready, Err
    );
endinterface

// File: rtl/mem_datos_sinc.sv
// Synchronous data memory: sized loads/stores, registered read, clear sweep.
// Define MEM_ALIGN_CHK_EN to suppress and flag misaligned accesses on Err.
module mem_datos_sinc #(
    parameter int          AW       = 8,
    parameter logic [31:0] INIT_VAL = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_datos_sinc_if.slave bus
);
    localparam int DEPTH = 2 ** AW;

    typedef enum logic {INIT, IDLE} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] ptr, ptr_nxt;
    logic [31:0]   mem [DEPTH];

    logic          sz_b, sz_h, sz_w;
    logic          acc, mis, wr_en, rd_en;
    logic [AW-1:0] idx, widx;
    logic [3:0]    be;
    logic [31:0]   wd, word, rdata;
    logic [7:0]    byt;
    logic [15:0]   half;
    logic [31:0]   dout_q;
    logic          valid_q;
    logic          dir_unused;

    assign sz_b = bus.Tam == 2'b00;
    assign sz_h = bus.Tam == 2'b01;
    assign sz_w = bus.Tam[1];
    assign idx  = bus.Dir[AW+1:2];
    assign acc  = bus.Req && state == IDLE;
    // Address bits above the array wrap silently.
    assign dir_unused = ^bus.Dir[31:AW+2];

`ifdef MEM_ALIGN_CHK_EN
    logic err_q;

    assign mis = (sz_h && bus.Dir[0]) ||
                 (sz_w && bus.Dir[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= acc && mis;
    end

    assign bus.Err = err_q;
`else
    assign mis     = 1'b0;
    assign bus.Err = 1'b0;
`endif

    assign wr_en     = acc && bus.Ewr && !mis;
    assign rd_en     = acc && !bus.Ewr && !mis;
    assign bus.Ready = state == IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        if (state == INIT) begin
            ptr_nxt = ptr + AW'(1);
            if (&ptr) state_nxt = IDLE;
        end
    end

    // The sweep owns the write port until Ready rises.
    always_comb begin
        be   = 4'b0000;
        wd   = bus.Din;
        widx = idx;
        if (state == INIT) begin
            be   = 4'b1111;
            wd   = INIT_VAL;
            widx = ptr;
        end else if (wr_en) begin
            unique case (1'b1)
                sz_b: begin
                    be = 4'b0001 << bus.Dir[1:0];
                    wd = {4{bus.Din[7:0]}};
                end
                sz_h: begin
                    be = bus.Dir[1] ? 4'b1100 : 4'b0011;
                    wd = {2{bus.Din[15:0]}};
                end
                sz_w:    be = 4'b1111;
                default: be = 4'b1111;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[widx][8*i +: 8] <= wd[8*i +: 8];
        end
    end

    always_comb begin
        word  = mem[idx];
        byt   = word[{bus.Dir[1:0], 3'b000} +: 8];
        half  = bus.Dir[1] ? word[31:16] : word[15:0];
        rdata = word;
        unique case (1'b1)
            sz_b:    rdata = {{24{bus.Sig & byt[7]}}, byt};
            sz_h:    rdata = {{16{bus.Sig & half[15]}}, half};
            sz_w:    rdata = word;
            default: rdata = word;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= rd_en;
            if (rd_en) dout_q <= rdata;
        end
    end

    assign bus.Dout  = dout_q;
    assign bus.Valid = valid_q;
endmodule

// File: tb/tb_mem_datos_sinc.sv
// Bench for mem_datos_sinc: vector table plus scoreboard of read results.
// Build with MEM_ALIGN_CHK_EN defined to exercise the alignment trap.
module tb_mem_datos_sinc;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    typedef struct {
        logic        ewr;
        logic [1:0]  tam;
        logic        sig;
        logic [31:0] dir;
        logic [31:0] din;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] exp;
        int          due;
        string       name;
    } sb_t;

    sb_t  sb[$];
    vec_t tv[20];

`ifdef MEM_ALIGN_CHK_EN
    localparam logic [31:0] ALW = 32'h80AD_BEEF;
    localparam logic [31:0] AE  = 32'd1;
`else
    localparam logic [31:0] ALW = 32'h1234_5678;
    localparam logic [31:0] AE  = 32'd0;
`endif

    mem_datos_sinc_if bus();

    mem_datos_sinc #(
        .AW      (8),
        .INIT_VAL(32'h0000_0000)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ewr, input logic [1:0] tam,
                                input logic sig, input logic [31:0] dir,
                                input logic [31:0] din, input logic [31:0] exp);
        vec_t v;
        v.ewr = ewr; v.tam = tam; v.sig = sig;
        v.dir = dir; v.din = din; v.exp = exp;
        return v;
    endfunction

    task automatic push(input logic [31:0] exp, input logic [31:0] dir);
        sb_t e;
        e.exp  = exp;
        e.due  = cyc + 1;
        e.name = $sformatf("rd@%h", dir);
        sb.push_back(e);
    endtask

    // Called just after a rising edge; the access is accepted on the next one.
    task automatic drive(input vec_t v, input bit want);
        bus.Req = 1'b1;
        bus.Ewr = v.ewr;
        bus.Tam = v.tam;
        bus.Sig = v.sig;
        bus.Dir = v.dir;
        bus.Din = v.din;
        if (!v.ewr && want) push(v.exp, v.dir);
        @(posedge clk); #1;
    endtask

    task automatic idle();
        bus.Req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.Ready !== 1'b1 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        chk(nm, 32'(n), 32'd256);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                chk({sb[0].name, " valid"}, 32'(bus.Valid), 32'd1);
                chk(sb[0].name, bus.Dout, sb[0].exp);
                void'(sb.pop_front());
            end else if (bus.Valid !== 1'b0) begin
                chk("stray valid", 32'(bus.Valid), 32'd0);
            end
        end
    end

    initial begin
        tv[0]  = mk(1, 2'd2, 0, 32'h10,  32'hDEAD_BEEF, 32'h0);
        tv[1]  = mk(0, 2'd2, 0, 32'h10,  32'h0,         32'hDEAD_BEEF);
        tv[2]  = mk(1, 2'd0, 0, 32'h13,  32'hFFFF_FF80, 32'h0);
        tv[3]  = mk(0, 2'd0, 1, 32'h13,  32'h0,         32'hFFFF_FF80);
        tv[4]  = mk(0, 2'd0, 0, 32'h13,  32'h0,         32'h0000_0080);
        tv[5]  = mk(0, 2'd2, 0, 32'h10,  32'h0,         32'h80AD_BEEF);
        tv[6]  = mk(1, 2'd1, 0, 32'h22,  32'hAAAA_8001, 32'h0);
        tv[7]  = mk(0, 2'd1, 1, 32'h22,  32'h0,         32'hFFFF_8001);
        tv[8]  = mk(0, 2'd2, 0, 32'h20,  32'h0,         32'h8001_0000);
        tv[9]  = mk(0, 2'd1, 0, 32'h22,  32'h0,         32'h0000_8001);
        tv[10] = mk(1, 2'd1, 0, 32'h30,  32'hFFFF_7FFF, 32'h0);
        tv[11] = mk(0, 2'd1, 1, 32'h30,  32'h0,         32'h0000_7FFF);
        tv[12] = mk(0, 2'd0, 1, 32'h31,  32'h0,         32'h0000_007F);
        tv[13] = mk(0, 2'd3, 1, 32'h30,  32'h0,         32'h0000_7FFF);
        tv[14] = mk(1, 2'd0, 0, 32'h41,  32'h1234_56A5, 32'h0);
        tv[15] = mk(0, 2'd2, 0, 32'h40,  32'h0,         32'h0000_A500);
        tv[16] = mk(0, 2'd0, 1, 32'h41,  32'h0,         32'hFFFF_FFA5);
        tv[17] = mk(0, 2'd2, 0, 32'h10,  32'h0,         32'h80AD_BEEF);
        tv[18] = mk(0, 2'd2, 0, 32'h20,  32'h0,         32'h8001_0000);
        tv[19] = mk(0, 2'd2, 0, 32'h410, 32'h0,         32'h80AD_BEEF);

        bus.Req = 1'b1;
        bus.Ewr = 1'b0;
        bus.Tam = 2'd2;
        bus.Sig = 1'b0;
        bus.Dir = 32'h3FC;
        bus.Din = 32'h0;

        #12;
        chk("rst Dout",  bus.Dout,         32'h0);
        chk("rst Valid", 32'(bus.Valid),   32'd0);
        chk("rst Ready", 32'(bus.Ready),   32'd0);
        chk("rst Err",   32'(bus.Err),     32'd0);

        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_ready("sweep cycles");
        push(32'h0, 32'h3FC);
        @(posedge clk); #1;
        idle();

        for (int i = 0; i < 20; i++) drive(tv[i], 1'b1);
        idle();
        idle();

        drive(mk(1, 2'd2, 0, 32'h11, 32'h1234_5678, 32'h0), 1'b1);
        chk("err wr misal", 32'(bus.Err), AE);
        drive(mk(0, 2'd2, 0, 32'h10, 32'h0, ALW), 1'b1);
        chk("err rd align", 32'(bus.Err), 32'd0);
        drive(mk(0, 2'd2, 0, 32'h12, 32'h0, ALW), AE == 32'd0);
        chk("err rd misal", 32'(bus.Err), AE);
        idle();
        chk("err clear", 32'(bus.Err), 32'd0);
        idle();

        drive(mk(0, 2'd2, 0, 32'h10, 32'h0, ALW), 1'b1);
        drive(mk(0, 2'd2, 0, 32'h20, 32'h0, 32'h8001_0000), 1'b1);
        chk("b2b valid", 32'(bus.Valid), 32'd1);
        #1 rst_n = 1'b0;
        sb.delete();
        bus.Req = 1'b0;
        #1;
        chk("mid rst Valid", 32'(bus.Valid), 32'd0);
        chk("mid rst Dout",  bus.Dout,       32'h0);
        chk("mid rst Ready", 32'(bus.Ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_ready("resweep cycles");
        @(posedge clk); #1;
        drive(mk(0, 2'd2, 0, 32'h10, 32'h0, 32'h0), 1'b1);
        idle();
        idle();
        chk("sb drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
